// File: rtl/rfifo_fwft_out.sv
// rfifo_fwft_out: read-side output stage of the asynchronous FIFO.
// Issues read increments from registered state only, captures the word the
// FIFO memory presents, and holds up to two words in a first-word-fall-through
// buffer feeding a valid/ready stream.
// Optional build macro RFIFO_RD_CNT_EN adds a 16-bit wrapping pop counter rd_cnt.
module rfifo_fwft_out #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            occ
`ifdef RFIFO_RD_CNT_EN
  ,
  output logic [15:0]           rd_cnt
`endif
);

  // Buffer occupancy doubles as the state encoding.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] head_next;
  logic [DATA_WIDTH-1:0] skid;
  logic [DATA_WIDTH-1:0] skid_next;
  logic                  push;
  logic                  pop;

  // Read request depends only on registered empty flag, occupancy and reset,
  // so the consumer's ready never reaches rinc combinationally.
  always_comb begin
    rinc       = !rempty && (state != TWO) && !rrst;
    push       = rinc;
    dout_valid = (state != EMPTY);
    pop        = dout_valid && dout_ready;
    dout       = head;
    occ        = state;
  end

  // Next-state and data-path selection for the two-entry buffer.
  always_comb begin
    state_next = state;
    head_next  = head;
    skid_next  = skid;
    case (state)
      EMPTY: begin
        if (push) begin
          state_next = ONE;
          head_next  = rdata;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_next = rdata;
        end else if (push) begin
          state_next = TWO;
          skid_next  = rdata;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_next = ONE;
          head_next  = skid;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // State and data registers; reset discards every buffered word.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      state <= state_next;
      head  <= head_next;
      skid  <= skid_next;
    end
  end

`ifdef RFIFO_RD_CNT_EN
  // Free-running count of words handed to the consumer, wrapping at 16 bits.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rd_cnt <= 16'd0;
    end else if (pop) begin
      rd_cnt <= rd_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rfifo_fwft_out.sv
// Testbench for rfifo_fwft_out: table-driven directed vectors, hand-written
// multi-cycle sequences and a randomized run checked against a queue model.
module tb_rfifo_fwft_out;

  localparam int DW = 8;

  logic          rclk = 1'b0;
  logic          rrst;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rinc;
  logic          dout_valid;
  logic          dout_ready;
  logic [DW-1:0] dout;
  logic [1:0]    occ;
`ifdef RFIFO_RD_CNT_EN
  logic [15:0]   rd_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of buffered words, pop counter, source word counter.
  logic [7:0] mq[$];
  logic [7:0] popped[$];
  int         m_cnt;
  int         src_cnt;
  logic       last_push;
  logic       chk_en = 1'b0;

  typedef struct {
    logic       rrst;
    logic       rempty;
    logic [7:0] rdata;
    logic       ready;
    logic       exp_rinc;
    logic       exp_valid;
    logic [7:0] exp_dout;
    logic [1:0] exp_occ;
  } vec_t;

  vec_t vecs[15];

  always #5 rclk = ~rclk;

  rfifo_fwft_out #(.DATA_WIDTH(DW)) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .rempty     (rempty),
    .rdata      (rdata),
    .rinc       (rinc),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout       (dout),
    .occ        (occ)
`ifdef RFIFO_RD_CNT_EN
    ,
    .rd_cnt     (rd_cnt)
`endif
  );

  // Occupancy range and rinc-vs-empty invariants, sampled mid-cycle.
  always @(negedge rclk) begin
    if (chk_en && !rrst) begin
      assert (occ <= 2'd2) else begin
        n_bad++;
        $display("[TB] FAIL occ_range: got %0d required <=2", occ);
      end
      assert (!(rinc && rempty)) else begin
        n_bad++;
        $display("[TB] FAIL rinc_while_empty: got rinc=%0b with rempty=1 required rinc=0", rinc);
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input logic e_rinc, input logic e_valid, input logic [7:0] e_dout,
                             input logic chk_dout, input logic [1:0] e_occ);
    cmp("rinc", int'(rinc), int'(e_rinc));
    cmp("dout_valid", int'(dout_valid), int'(e_valid));
    cmp("occ", int'(occ), int'(e_occ));
    if (chk_dout) cmp("dout", int'(dout), int'(e_dout));
  endtask

  // Drive one cycle, compare against the model, clock, then advance the model.
  task automatic applyStimulus(input logic r, input logic e, input logic [7:0] d, input logic rdy);
    logic m_rinc;
    rrst = r; rempty = e; rdata = d; dout_ready = rdy;
    #1;
    m_rinc = !e && (mq.size() < 2) && !r;
    checkOutput(m_rinc, mq.size() != 0, (mq.size() != 0) ? mq[0] : 8'h00,
                mq.size() != 0, 2'(mq.size()));
`ifdef RFIFO_RD_CNT_EN
    cmp("rd_cnt", int'(rd_cnt), m_cnt);
`endif
    @(posedge rclk);
    last_push = 1'b0;
    if (r) begin
      mq.delete();
      m_cnt = 0;
    end else begin
      if (mq.size() != 0 && rdy) begin
        popped.push_back(mq.pop_front());
        m_cnt = (m_cnt + 1) & 16'hFFFF;
      end
      if (m_rinc) begin
        mq.push_back(d);
        last_push = 1'b1;
      end
    end
    #1;
  endtask

  // Present the next source word; the source advances only when it is consumed.
  task automatic srcStep(input logic r, input logic e, input logic rdy);
    logic [7:0] w;
    w = src_cnt[7:0];
    applyStimulus(r, e, w, rdy);
    if (last_push) src_cnt++;
  endtask

  initial begin
    // reset, single word, back-pressure and refill
    vecs[0]  = '{1, 0, 8'h55, 0, 0, 0, 8'h00, 2'd0};
    vecs[1]  = '{1, 0, 8'h55, 0, 0, 0, 8'h00, 2'd0};
    vecs[2]  = '{0, 0, 8'hA5, 0, 1, 0, 8'h00, 2'd0};
    vecs[3]  = '{0, 1, 8'h33, 0, 0, 1, 8'hA5, 2'd1};
    vecs[4]  = '{0, 1, 8'h33, 0, 0, 1, 8'hA5, 2'd1};
    vecs[5]  = '{0, 1, 8'h33, 1, 0, 1, 8'hA5, 2'd1};
    vecs[6]  = '{0, 1, 8'h33, 0, 0, 0, 8'hA5, 2'd0};
    vecs[7]  = '{0, 0, 8'h01, 0, 1, 0, 8'hA5, 2'd0};
    vecs[8]  = '{0, 0, 8'h02, 0, 1, 1, 8'h01, 2'd1};
    vecs[9]  = '{0, 0, 8'h03, 0, 0, 1, 8'h01, 2'd2};
    vecs[10] = '{0, 0, 8'h03, 0, 0, 1, 8'h01, 2'd2};
    vecs[11] = '{0, 0, 8'h03, 1, 0, 1, 8'h01, 2'd2};
    vecs[12] = '{0, 0, 8'h03, 1, 1, 1, 8'h02, 2'd1};
    vecs[13] = '{0, 1, 8'h00, 1, 0, 1, 8'h03, 2'd1};
    vecs[14] = '{0, 1, 8'h00, 0, 0, 0, 8'h03, 2'd0};

    rrst = 1'b1; rempty = 1'b0; rdata = 8'h00; dout_ready = 1'b0;
    m_cnt = 0; src_cnt = 0; last_push = 1'b0;
    @(posedge rclk);
    #1;
    chk_en = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 15; i++) begin
      rrst = vecs[i].rrst; rempty = vecs[i].rempty;
      rdata = vecs[i].rdata; dout_ready = vecs[i].ready;
      #1;
      checkOutput(vecs[i].exp_rinc, vecs[i].exp_valid, vecs[i].exp_dout, 1'b1, vecs[i].exp_occ);
      @(posedge rclk);
      #1;
    end

    $display("[TB] streaming 0x10..0x17");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    popped.delete();
    src_cnt = 'h10;
    for (int c = 0; c < 14; c++) srcStep(1'b0, src_cnt >= 'h18, 1'b1);
    cmp("stream_count", popped.size(), 8);
    for (int k = 0; k < 8 && k < popped.size(); k++) cmp("stream_word", int'(popped[k]), 'h10 + k);

    $display("[TB] randomized run");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    popped.delete();
    src_cnt = 0;
    for (int c = 0; c < 1000; c++) srcStep(1'b0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    for (int c = 0; c < 4; c++) srcStep(1'b0, 1'b1, 1'b1);
    cmp("random_drained", popped.size(), src_cnt);
    for (int k = 0; k < popped.size(); k++) begin
      if (popped[k] != 8'(k)) cmp("random_order", int'(popped[k]), k & 'hFF);
    end

    $display("[TB] reset with two words buffered");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    popped.delete();
    src_cnt = 'h40;
    for (int c = 0; c < 20 && popped.size() < 5; c++) srcStep(1'b0, 1'b0, 1'b1);
    cmp("pops_before_reset", popped.size(), 5);
    for (int c = 0; c < 5 && mq.size() < 2; c++) srcStep(1'b0, 1'b0, 1'b0);
    cmp("occ_before_reset", int'(occ), 2);
    applyStimulus(1'b1, 1'b0, 8'h77, 1'b1);
    cmp("occ_after_reset", int'(occ), 0);
    cmp("valid_after_reset", int'(dout_valid), 0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);

`ifdef RFIFO_RD_CNT_EN
    $display("[TB] rd_cnt wrap");
    cmp("rd_cnt_after_reset", int'(rd_cnt), 0);
    for (int c = 0; c < 70000 && m_cnt != 'hFFFF; c++) begin
      srcStep(1'b0, 1'b0, 1'b1);
      if (c % 1000 == 0) popped.delete();
    end
    cmp("rd_cnt_preload", int'(rd_cnt), 'hFFFF);
    for (int c = 0; c < 4 && m_cnt != 0; c++) srcStep(1'b0, 1'b0, 1'b1);
    cmp("rd_cnt_wrap", int'(rd_cnt), 0);
`endif

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rfifo_fwft_out.md
Name: rfifo_fwft_out

Overview:
- Read-side output stage of the asynchronous FIFO, directly downstream of the read-pointer/empty-flag logic.
- Watches the registered empty flag and issues read increments. Captures the word the combinational FIFO memory presents at the current read address.
- Holds captured words in a 2-entry first-word-fall-through buffer and presents them on a valid/ready stream.
- The read increment is a function of registered state only. There is no combinational path from dout_ready to rinc.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and of dout.

Ports:
- rclk  input  1  read-domain clock; all state updates on its rising edge.
- rrst  input  1  synchronous active-high reset, sampled on rising rclk.
- rempty  input  1  registered empty flag from the read-pointer logic; 1 = no word at the current read address.
- rdata  input  DATA_WIDTH  FIFO memory read data at the current read address; combinational, valid whenever rempty=0.
- rinc  output  1  read increment to the read-pointer logic; one word consumed per cycle it is high.
- dout_valid  output  1  head word on dout is valid.
- dout_ready  input  1  consumer accepts the head word this cycle.
- dout  output  DATA_WIDTH  head word.
- occ  output  2  number of buffered words, 0..2.

Behaviour:
- State:
  - head register and skid register, each DATA_WIDTH.
  - occ register, 0..2.
  - Encoding: EMPTY = occ 0, ONE = occ 1, TWO = occ 2.
- Reset (rrst=1 at an edge):
  - occ=0, dout_valid=0, dout=0.
  - skid cleared to 0.
  - rinc is held 0 during any cycle with rrst=1.
- rinc:
  - rinc = !rempty && (occ < 2) && !rrst. It is purely combinational from registered inputs.
  - rinc is never asserted while rempty=1.
- Push: push = rinc. The word pushed is the value of rdata in that same cycle.
- Pop: pop = dout_valid && dout_ready.
- Outputs: dout_valid = (occ != 0); dout = head.
- Transitions (push, pop):
  - EMPTY, push -> ONE. head <= rdata. Latency: 1 cycle from rinc to dout_valid.
  - EMPTY, no push -> stay in EMPTY.
  - ONE, push, no pop -> TWO. skid <= rdata.
  - ONE, push and pop -> stay in ONE. head <= rdata. This is full throughput: 1 word per cycle.
  - ONE, pop, no push -> EMPTY.
  - TWO, pop -> ONE. head <= skid. No push can occur because occ=2 blocks rinc.
  - TWO, no pop -> stay in TWO. head and skid are held.
- Ordering: words leave in exactly the order rinc consumed them. No drops, no duplicates.
- dout is stable while dout_valid=1 and dout_ready=0.
- dout_ready while dout_valid=0 has no effect.
- Empty boundary: if rempty rises in the same cycle as a pop, the stage drains normally; no further rinc is issued.
- Full boundary (occ=2): rinc stays 0 regardless of rempty. It resumes in the cycle after occ drops below 2.
- Reset mid-operation: all buffered words are discarded. The read-pointer logic is reset in the same cycle by the shared reset controller. Words in flight are not recovered.
- Occupancy never exceeds 2 and never underflows. An assertion is required in the bench.

Optional Feature:
- Macro: RFIFO_RD_CNT_EN.
- Defined:
  - Adds output port rd_cnt, 16 bits.
  - rd_cnt increments by 1 on every pop and wraps 0xFFFF -> 0x0000.
  - Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rrst=1 for 2 cycles with rempty=0 -> rinc=0, dout_valid=0, occ=0, dout=0 throughout.
- Single word: rempty=0 for 1 cycle with rdata=0xA5, dout_ready=0 -> rinc=1 that cycle; next cycle dout_valid=1, dout=0xA5, occ=1; word held until dout_ready=1, then occ=0.
- Back-pressure: rempty=0, rdata sequence 0x01,0x02,0x03, dout_ready=0 -> exactly 2 rincs; occ=2; rinc=0 afterward. Releasing dout_ready yields 0x01, 0x02, then 0x03 after a refill rinc.
- Streaming: rempty=0 with 8 words 0x10..0x17, dout_ready=1 -> after the first-word latency, one pop per cycle; output exactly 0x10..0x17 in order; occ stays 1 in steady state.
- Random: random rempty and dout_ready toggling over 1000 cycles with an incrementing rdata per rinc -> scoreboard matches, no loss or duplication, occ stays in 0..2, rinc never high with rempty=1.
- Mid-operation reset (RFIFO_RD_CNT_EN defined): rrst=1 at occ=2 after 5 pops -> next cycle occ=0, dout_valid=0, rd_cnt=0. Preload rd_cnt=0xFFFF via 65535 pops, one more pop -> rd_cnt=0x0000.
